// File: rtl/qrd_skew_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : qrd_skew_scheduler
//  Brief    : Row-feed controller for the QRD-RLS array: triangular input
//             skew per column, per-frame row counting, drain and frame_done.
//  Revision : 1.0
// ============================================================================
module qrd_skew_scheduler #(
  parameter int N           = 5,
  parameter int DATA_LENGTH = 8,
  parameter int ROWS        = 16,
  parameter int PE_LAT      = 20,
  parameter int RW          = $clog2(ROWS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*DATA_LENGTH-1:0] in_data,
  output logic [N*DATA_LENGTH-1:0] col_data,
  output logic [N-1:0]             col_valid,
  output logic [RW-1:0]            row_cnt,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int              c_DW          = $clog2(N + PE_LAT + 1);
  localparam logic [RW-1:0]   c_ROWS_LAST   = RW'(ROWS - 1);
  localparam logic [c_DW-1:0] c_DRAIN_LAST  = c_DW'(N + PE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [RW-1:0]   r_row_cnt;
  logic [RW-1:0]   w_row_cnt_next;
  logic [c_DW-1:0] r_drain_cnt;
  logic [c_DW-1:0] w_drain_next;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_frame_done;
  logic            w_acc;

  assign w_acc = in_valid & r_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row_cnt    <= '0;
      r_drain_cnt  <= '0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_row_cnt    <= w_row_cnt_next;
      r_drain_cnt  <= w_drain_next;
      // Status flags are decoded from the next state so they are true registers.
      r_in_ready   <= (w_state_next == S_FEED);
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= (w_state_next == S_DONE);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_row_cnt_next = r_row_cnt;
    w_drain_next   = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next   = S_FEED;
          w_row_cnt_next = '0;
          w_drain_next   = '0;
        end
      end
      S_FEED: begin
        if (w_acc) begin
          w_row_cnt_next = r_row_cnt + 1'b1;
          if (r_row_cnt == c_ROWS_LAST) begin
            w_state_next = S_DRAIN;
            w_drain_next = '0;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == c_DRAIN_LAST) begin
          w_state_next = S_DONE;
          w_drain_next = '0;
        end else begin
          w_drain_next = r_drain_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Lane k is k+1 registers deep; the shift runs every cycle regardless of state.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DATA_LENGTH-1:0] r_dsr [0:k];
    logic [k:0]             r_vsr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vsr <= '0;
        for (int s = 0; s <= k; s++) r_dsr[s] <= '0;
      end else begin
        r_vsr[0] <= w_acc;
        r_dsr[0] <= in_data[k*DATA_LENGTH +: DATA_LENGTH];
        for (int s = 1; s <= k; s++) begin
          r_vsr[s] <= r_vsr[s-1];
          r_dsr[s] <= r_dsr[s-1];
        end
      end
    end

    assign col_data[k*DATA_LENGTH +: DATA_LENGTH] = r_dsr[k];
    assign col_valid[k]                           = r_vsr[k];
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign row_cnt    = r_row_cnt;

endmodule
`default_nettype wire

// File: tb/tb_qrd_skew_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qrd_skew_scheduler
//  Brief    : Directed bench for qrd_skew_scheduler (ROWS=4 and ROWS=1 builds).
//  Revision : 1.0
// ============================================================================
module tb_qrd_skew_scheduler;

  localparam int N    = 5;
  localparam int DL   = 8;
  localparam int ROWS = 4;
  localparam int PE   = 3;
  localparam int RW   = $clog2(ROWS + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [N*DL-1:0] in_data = '0;
  logic            in_ready;
  logic [N*DL-1:0] col_data;
  logic [N-1:0]    col_valid;
  logic [RW-1:0]   row_cnt;
  logic            busy;
  logic            frame_done;

  logic            start1 = 1'b0;
  logic            vld1 = 1'b0;
  logic [N*DL-1:0] data1 = '0;
  logic            ir1;
  logic [N*DL-1:0] cd1;
  logic [N-1:0]    cv1;
  logic [0:0]      rc1;
  logic            busy1;
  logic            fd1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  qrd_skew_scheduler #(.N(N), .DATA_LENGTH(DL), .ROWS(ROWS), .PE_LAT(PE)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .col_data(col_data), .col_valid(col_valid), .row_cnt(row_cnt),
    .busy(busy), .frame_done(frame_done)
  );

  qrd_skew_scheduler #(.N(N), .DATA_LENGTH(DL), .ROWS(1), .PE_LAT(PE)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(vld1), .in_ready(ir1),
    .in_data(data1), .col_data(cd1), .col_valid(cv1), .row_cnt(rc1),
    .busy(busy1), .frame_done(fd1)
  );

  typedef struct {
    logic          start;
    logic          vld;
    logic          ir;
    logic [RW-1:0] rc;
    logic          busy;
    logic [N-1:0]  cv;
    logic          fd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input bit with_data);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_row_cnt"}, 64'(row_cnt), 64'd0);
    chk({tag, "_col_valid"}, 64'(col_valid), 64'd0);
    if (with_data) chk({tag, "_col_data"}, 64'(col_data), 64'd0);
  endtask

  function automatic logic [N*DL-1:0] mk_row(input int r);
    logic [N*DL-1:0] v;
    for (int k = 0; k < N; k++) v[k*DL +: DL] = 8'(16 * r + k);
    return v;
  endfunction

  initial begin
    int lat;
    int a0, a1, fdc;
    int d;

    //              start vld ir  rc    busy cv        fd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 5'b00000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'b00001, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 5'b00101, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 5'b01011, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 5'b10110, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 5'b01101, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 5'b11010, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b10100, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b01000, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b10000, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b00000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b00000, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b00000, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'b00000, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 5'b00000, 1'b0};

    // Reset and idle: in_valid offered without start must never be taken.
    repeat (3) tick();
    chk_idle("reset", 1'b1);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("idle", 1'b0);
    end
    in_valid = 1'b0;

    // Bubble pattern 1,0,1,1,0,1 with stray start pulses in FEED and DRAIN.
    for (int i = 0; i < 17; i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].vld;
      in_data  = mk_row(i);
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].ir));
      chk("tbl_row_cnt", 64'(row_cnt), 64'(tbl[i].rc));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].busy));
      chk("tbl_col_valid", 64'(col_valid), 64'(tbl[i].cv));
      chk("tbl_frame_done", 64'(frame_done), 64'(tbl[i].fd));
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;

    // Skew: four back-to-back rows, element k of row r = 8'h10*r + k.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 15; j++) begin
      in_valid = (j < 4);
      in_data  = (j < 4) ? mk_row(j) : '1;
      chk("skew_in_ready", 64'(in_ready), 64'(j < 4));
      chk("skew_busy", 64'(busy), 64'(j <= 12));
      chk("skew_frame_done", 64'(frame_done), 64'(j == 12));
      for (int k = 0; k < N; k++) begin
        d = j - k - 1;
        chk("skew_col_valid", 64'(col_valid[k]), 64'(d >= 0 && d < 4));
        if (d >= 0 && d < 4)
          chk("skew_col_data", 64'(col_data[k*DL +: DL]), 64'(8'(16 * d + k)));
      end
      tick();
    end
    in_valid = 1'b0;

    // Asynchronous reset in the middle of DRAIN.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = mk_row(i + 5);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset", 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("post_reset_frame_done", 64'(frame_done), 64'd0);
    end
    chk("post_reset_busy", 64'(busy), 64'd0);

    // Clean frame after the reset: drain latency from last accept.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = mk_row(i);
      if (i < 3) tick();
    end
    lat = 0;
    do begin
      tick();
      in_valid = 1'b0;
      lat++;
    end while (!frame_done && lat < 40);
    chk("drain_latency", 64'(lat), 64'(N + PE + 1));
    chk("done_row_cnt", 64'(row_cnt), 64'(ROWS));
    tick();
    chk("after_done_busy", 64'(busy), 64'd0);

    // ROWS=1 with start and in_valid held high: back-to-back frames.
    start1 = 1'b1;
    vld1   = 1'b1;
    a0 = -1;
    a1 = -1;
    fdc = -1;
    for (int i = 0; i < 40; i++) begin
      data1 = mk_row(i);
      if (vld1 && ir1) begin
        if (a0 < 0) a0 = i;
        else if (a1 < 0) a1 = i;
      end
      if (fd1 && fdc < 0) begin
        fdc = i;
        chk("r1_done_row_cnt", 64'(rc1), 64'd1);
      end
      tick();
    end
    start1 = 1'b0;
    vld1   = 1'b0;
    chk("r1_first_acc_seen", 64'(a0 >= 0), 64'd1);
    chk("r1_done_latency", 64'(fdc - a0), 64'(N + PE + 1));
    chk("r1_frame_period", 64'(a1 - a0), 64'(1 + N + PE + 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
